divisor_iter: RTL
=================

// Module: divisor_iter
// PURPOSE
//   Parametrised multi-cycle restoring divider for the ALU datapath; next generation of the fixed 32-bit divider.
//   Computes quotient into LO and remainder into HI, MIPS div/divu semantics, selectable signed/unsigned per operation.
//   Adds start/busy/done handshake, sticky divide-by-zero flag, signed correction and width generalisation.
//   Sits beside the multiplier; control unit pulses DivCtrl and waits on done before reading HI/LO.
// PARAMETERS
//   WIDTH      32   operand/result width in bits (>=4)
//   CNT_W      6    iteration counter width, must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk         in   1      single clock, all state changes on rising edge
//   reset       in   1      one clock; reset is asynchronous and active-low
//   DivCtrl     in   1      start request, sampled only in IDLE
//   DivSigned   in   1      1 = signed (div), 0 = unsigned (divu); sampled with DivCtrl
//   dividendo   in   WIDTH  dividend, sampled with DivCtrl
//   divisor     in   WIDTH  divisor, sampled with DivCtrl
//   HI          out  WIDTH  remainder of last successful division
//   LO          out  WIDTH  quotient of last successful division
//   divZero     out  1      set when started with divisor==0; cleared on next accepted start
//   busy        out  1      high while an operation is in progress (not IDLE)
//   done        out  1      one-cycle pulse: operation finished (success or div-by-zero)
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE; HI=0, LO=0, divZero=0, busy=0, done=0; all internal regs 0.
//   States: IDLE -> RUN -> FIX -> IDLE; IDLE -> ZERO -> IDLE for divisor==0.
//   IDLE: edge with DivCtrl=1 accepts (call it edge E0): latch |dividendo|, |divisor| (magnitude only if DivSigned
//     and MSB=1), quotient sign = sign(dnd) XOR sign(dvs), remainder sign = sign(dnd); clear divZero; count=0;
//     busy=1 from E0. divisor==0 -> ZERO, else -> RUN.
//   RUN: one quotient bit per edge, restoring: rem={rem[WIDTH-1:0],dnd_msb}; if rem>=dvs then rem-=dvs, qbit=1.
//     Internal remainder WIDTH+1 bits (no overflow). Exactly WIDTH edges (E1..E_WIDTH), then -> FIX.
//   FIX (edge E_WIDTH+1): LO = quotient negated if quotient sign=1; HI = remainder negated if remainder sign=1;
//     done=1 for the following cycle; busy=0; -> IDLE. Total latency WIDTH+1 edges from E0 to HI/LO update.
//   ZERO (edge E1): divZero=1, done=1 for following cycle, busy=0, HI/LO unchanged; -> IDLE.
//   Quotient truncates toward zero; remainder takes dividend sign; |HI| < |divisor|.
//   Signed MIN/-1 (e.g. 0x8000_0000 / 0xFFFF_FFFF): LO=MIN, HI=0 (wraps, no trap, no flag).
//   Unsigned mode: operands never negated, sign bits ignored.
//   DivCtrl while busy: ignored, no queueing; operands/DivSigned changes while busy have no effect.
//   DivCtrl in the same cycle done is high: accepted (FSM already IDLE); back-to-back ops allowed.
//   HI/LO hold their value between operations and are written only in FIX.
//   Reset mid-operation: aborts immediately, all outputs to reset values, no done pulse.
// TESTING (WIDTH=32)
//   unsigned 100 / 7 -> after 33 edges LO=14, HI=2, done one cycle, divZero=0
//   signed -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1); 7/-2 -> LO=-3, HI=1
//   signed 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0; unsigned same operands -> LO=0, HI=0x8000_0000
//   divisor=0 after a 100/7 op -> divZero=1, done at E1+1, HI=2/LO=14 retained; next valid start clears divZero
//   DivCtrl pulsed at E10 of running op -> ignored, result of first op unchanged, no extra done
//   reset low at E15 -> HI=LO=0, busy=0, no done; new start after release completes normally in 33 edges

Source files
------------

// File: rtl/divisor_iter_if.sv
// divisor_iter_if: start/operand/result bundle between control unit and divider
interface divisor_iter_if #(
  parameter int WIDTH = 32
);
  logic             DivCtrl;
  logic             DivSigned;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             divZero;
  logic             busy;
  logic             done;
  modport master (
    output DivCtrl, DivSigned, dividendo, divisor,
    input  HI, LO, divZero, busy, done
  );
  modport slave (
    input  DivCtrl, DivSigned, dividendo, divisor,
    output HI, LO, divZero, busy, done
  );
endinterface

// File: rtl/divisor_iter.sv
// divisor_iter: multi-cycle restoring divider, quotient to LO, remainder to HI, signed or unsigned
module divisor_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           reset,
  divisor_iter_if.slave d
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dnd_q, dnd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic             dnd_neg;
  logic             dvs_neg;
  assign rem_sh  = {rem_q, dnd_q[WIDTH-1]};
  assign ge      = rem_sh >= {1'b0, dvs_q};
  assign dnd_neg = d.DivSigned & d.dividendo[WIDTH-1];
  assign dvs_neg = d.DivSigned & d.divisor[WIDTH-1];
  assign d.HI      = hi_q;
  assign d.LO      = lo_q;
  assign d.divZero = dz_q;
  assign d.busy    = busy_q;
  assign d.done    = done_q;
  // next state: accept in IDLE, one restoring step per RUN edge, sign fix-up in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dnd_d   = dnd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (d.DivCtrl) begin
        dnd_d   = dnd_neg ? -d.dividendo : d.dividendo;
        dvs_d   = dvs_neg ? -d.divisor : d.divisor;
        qneg_d  = dnd_neg ^ dvs_neg;
        rneg_d  = dnd_neg;
        dz_d    = 1'b0;
        cnt_d   = '0;
        rem_d   = '0;
        quo_d   = '0;
        busy_d  = 1'b1;
        state_d = (d.divisor == '0) ? ZERO : RUN;
      end
      RUN: begin
        rem_d   = ge ? rem_sh[WIDTH-1:0] - dvs_q : rem_sh[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], ge};
        dnd_d   = {dnd_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
      end
      FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        dz_d    = 1'b1;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // state registers, cleared asynchronously so a reset aborts any operation at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dnd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dnd_q   <= dnd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule
